// File: rtl/case_convert_stream_pkg.sv
// Shared definitions for the case-conversion stream: conversion modes and
// the ASCII letter bounds used by every lane.
package case_convert_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_t;

  localparam logic [7:0] ASCII_UC_LO    = 8'h41;
  localparam logic [7:0] ASCII_UC_HI    = 8'h5A;
  localparam logic [7:0] ASCII_LC_LO    = 8'h61;
  localparam logic [7:0] ASCII_LC_HI    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/case_convert_lane.sv
// Single-byte case converter; purely combinational. Bytes outside the two
// letter ranges (including any with bit7 set) are never touched.
module case_convert_lane
  import case_convert_stream_pkg::*;
(
  input  logic [7:0] char_in,
  input  mode_t      mode,
  input  logic       keep,
  output logic [7:0] char_out,
  output logic       modified
);

  logic is_uc;
  logic is_lc;

  always_comb begin
    is_uc    = in_range(char_in, ASCII_UC_LO, ASCII_UC_HI);
    is_lc    = in_range(char_in, ASCII_LC_LO, ASCII_LC_HI);
    char_out = char_in;
    modified = 1'b0;
    if (keep) begin
      unique case (mode)
        MODE_UPPER: if (is_lc) begin
          char_out = char_in - ASCII_CASE_BIT;
          modified = 1'b1;
        end
        MODE_LOWER: if (is_uc) begin
          char_out = char_in + ASCII_CASE_BIT;
          modified = 1'b1;
        end
        MODE_TOGGLE: if (is_uc || is_lc) begin
          char_out = char_in ^ ASCII_CASE_BIT;
          modified = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/case_convert_stream.sv
// Streaming ASCII case converter: LANES bytes per beat, one-cycle latency,
// registered in_ready backed by a 2-entry skid buffer, saturating counter.
module case_convert_stream
  import case_convert_stream_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_keep,
  input  logic               in_sop,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_sop,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   conv_count
);

  localparam int DW    = 8 * LANES;
  localparam int NM_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + NM_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  mode_t            mode_q;
  mode_t            mode_eff;
  logic [1:0]       fill_q;
  logic [1:0]       fill_nxt;
  logic             in_ready_q;
  logic             acc;
  logic             pop;
  logic             ld0_in;
  logic             ld1_in;
  logic             ld0_sk;
  logic [CNT_W-1:0] count_q;
  logic [SUM_W-1:0] count_sum;

  logic [DW-1:0]    data_p0;
  logic [LANES-1:0] mod_p0;
  logic [NM_W-1:0]  nmod_p0;

  // Entry 0 drives the outputs; entry 1 is the skid slot.
  logic [DW-1:0]    data_p1 [2];
  logic [LANES-1:0] keep_p1 [2];
  logic [NM_W-1:0]  nmod_p1 [2];
  logic [1:0]       sop_p1;

  // Stage p0: combinational conversion of the incoming beat
  assign mode_eff = in_sop ? mode_t'(mode) : mode_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    case_convert_lane u_lane (
      .char_in  (in_data[8*i +: 8]),
      .mode     (mode_eff),
      .keep     (in_keep[i]),
      .char_out (data_p0[8*i +: 8]),
      .modified (mod_p0[i])
    );
  end

  always_comb begin
    nmod_p0 = '0;
    for (int i = 0; i < LANES; i++) nmod_p0 = nmod_p0 + NM_W'(mod_p0[i]);
  end

  assign acc      = in_valid && in_ready_q;
  assign pop      = (fill_q != 2'd0) && out_ready;
  assign fill_nxt = fill_q + {1'b0, acc} - {1'b0, pop};
  assign ld0_in   = acc && ((fill_q == 2'd0) || ((fill_q == 2'd1) && pop));
  assign ld1_in   = acc && (fill_q == 2'd1) && !pop;
  assign ld0_sk   = pop && (fill_q == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q     <= 2'd0;
      in_ready_q <= 1'b0;
      mode_q     <= MODE_PASS;
    end else begin
      fill_q     <= fill_nxt;
      in_ready_q <= (fill_nxt != 2'd2);
      if (acc && in_sop) mode_q <= mode_t'(mode);
    end
  end

  // Stage p1: skid buffer storage, cleared so no stale beat survives reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_p1[i] <= '0;
        keep_p1[i] <= '0;
        nmod_p1[i] <= '0;
      end
      sop_p1 <= '0;
    end else begin
      if (ld0_in) begin
        data_p1[0] <= data_p0;
        keep_p1[0] <= in_keep;
        nmod_p1[0] <= nmod_p0;
        sop_p1[0]  <= in_sop;
      end else if (ld0_sk) begin
        data_p1[0] <= data_p1[1];
        keep_p1[0] <= keep_p1[1];
        nmod_p1[0] <= nmod_p1[1];
        sop_p1[0]  <= sop_p1[1];
      end
      if (ld1_in) begin
        data_p1[1] <= data_p0;
        keep_p1[1] <= in_keep;
        nmod_p1[1] <= nmod_p0;
        sop_p1[1]  <= in_sop;
      end
    end
  end

  // Count is credited when the beat leaves, not when it is accepted
  assign count_sum = SUM_W'(count_q) + SUM_W'(nmod_p1[0]);

  always_ff @(posedge clk) begin
    if (!rst_n)       count_q <= '0;
    else if (cnt_clr) count_q <= '0;
    else if (pop)     count_q <= (count_sum > CNT_MAX) ? count_q | {CNT_W{1'b1}}
                                                       : count_sum[CNT_W-1:0];
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (fill_q != 2'd0);
  assign out_data   = data_p1[0];
  assign out_keep   = keep_p1[0];
  assign out_sop    = sop_p1[0];
  assign conv_count = count_q;

endmodule

// File: doc/case_convert_stream.md
CASE_CONVERT_STREAM -- requirements
Module: case_convert_stream

Interface
REQ-001 Parameter LANES, default 4, number of 8-bit character lanes per beat (1..16).
REQ-002 Parameter CNT_W, default 16, width of converted-character counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block can accept input beat.
REQ-007 in_data  input  8*LANES  characters, lane i = bits [8i+7:8i].
REQ-008 in_keep  input  LANES  per-lane enable; 0 = lane passes unchanged, not counted.
REQ-009 in_sop  input  1  first beat of message; mode sampled on this beat.
REQ-010 mode  input  2  0 PASS, 1 UPPER, 2 LOWER, 3 TOGGLE.
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_data  output  8*LANES  converted characters.
REQ-014 out_keep  output  LANES  in_keep delayed with its beat.
REQ-015 out_sop  output  1  in_sop delayed with its beat.
REQ-016 cnt_clr  input  1  clear conversion counter.
REQ-017 conv_count  output  CNT_W  saturating count of lanes actually modified.

Function
REQ-018 Transfer occurs on a valid&ready cycle; data, keep, sop shall never change while out_valid=1 and out_ready=0.
REQ-019 Latency in_data to out_data shall be exactly 1 cycle when out_ready held 1; throughput one beat per cycle.
REQ-020 in_ready shall be a register output (no combinational path from out_ready); a 2-entry skid buffer absorbs the beat in flight when out_ready drops.
REQ-021 in_ready shall be 1 when the skid buffer holds 0 or 1 entries and 0 when it holds 2.
REQ-022 Effective mode: on an accepted beat with in_sop=1, mode input is used and latched; on beats with in_sop=0, the latched mode is used.
REQ-023 Lowercase = 0x61..0x7A; uppercase = 0x41..0x5A; all other bytes (incl. bit7=1) never modified.
REQ-024 UPPER: lowercase byte minus 0x20; LOWER: uppercase byte plus 0x20; TOGGLE: either class, bit5 inverted; PASS: no change.
REQ-025 Conversion shall apply only to lanes with in_keep=1; other lanes copied bit-exact.
REQ-026 conv_count shall increase by the number of modified lanes of each beat at its output transfer, saturating at 2^CNT_W-1.
REQ-027 cnt_clr=1 shall force conv_count to 0 next cycle, overriding a simultaneous increment.
REQ-028 Mode change with in_sop=0 shall have no effect until the next sop beat.

Reset
REQ-029 On rst_n=0 at a clock edge: out_valid=0, in_ready=0 during reset, in_ready=1 first cycle after release, skid buffer empty, latched mode=PASS, conv_count=0, out_data/out_keep/out_sop=0.
REQ-030 Reset mid-message shall discard all buffered beats; no partial beat emitted after release.

Structure
REQ-031 Shared package holds mode enum (PASS/UPPER/LOWER/TOGGLE) and ASCII bound constants 0x41, 0x5A, 0x61, 0x7A, 0x20.
REQ-032 One combinational sub-module case_convert_lane (byte, mode, keep -> byte, modified flag), instantiated LANES times.

Verification
REQ-033 LANES=4, mode=UPPER, sop, data "abZ9" (0x39_5A_62_61 lane0=0x61) keep=0xF, out_ready=1 -> next cycle "ABZ9", conv_count=2.
REQ-034 mode=TOGGLE sop "aB{@" keep=0b0101 -> lanes0,2 toggled only: out "AB{@"; count +1 ({ unchanged).
REQ-035 Stream 8 beats, out_ready toggling 1,0,0,1 pattern -> all 8 beats out in order, none lost/duplicated, out_data stable while stalled.
REQ-036 sop beat mode=LOWER, next beat mode=UPPER with sop=0, data "ABCD" -> output "abcd".
REQ-037 CNT_W=4, 20 beats each 4 lowercase in UPPER -> conv_count saturates at 15; cnt_clr coincident with beat -> 0.
REQ-038 Assert rst_n=0 with 2 beats buffered -> out_valid=0 next cycle, count 0, mode PASS.
